bridge_timer: RTL and testbench

BRIDGE_TIMER -- requirements
Module: bridge_timer

---
 rtl/bridge_timer.sv | 137 +++++++++++++
 tb/tb_bridge_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bridge_timer.sv
// Memory-mapped countdown timer on the CPU bridge: CTRL/PRESET/COUNT registers,
// address-exception checking, and a registered interrupt request.
module bridge_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  Op,
  input  logic [4:0]  ExcCodeIn,
  input  logic        Req,
  output logic [31:0] ReadData,
  output logic [4:0]  ExcCodeOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [3:0]  ctrl_reg;
  logic [31:0] preset_reg;
  logic [31:0] count_reg;
  logic        irq_flag_reg;

  logic        sel;
  logic        is_load;
  logic        is_store;
  logic [3:0]  off_hit;
  logic [4:0]  exc;
  logic        we;
  logic        we_ctrl;
  logic        we_preset;

  // One-hot decode of the word offset inside the 16-byte block.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_off
      assign off_hit[gi] = (Addr[3:2] == 2'(gi));
    end
  endgenerate

  assign is_load  = (Op >= 4'd1) && (Op <= 4'd5);
  assign is_store = (Op >= 4'd6) && (Op <= 4'd8);
  assign sel      = (Addr[31:4] == BASE[31:4]) && (is_load || is_store);

  // A pending upstream exception always wins over our own address checks.
  always_comb begin
    exc = 5'd0;
    if (ExcCodeIn != 5'd0)
      exc = ExcCodeIn;
    else if (sel && is_load &&
             ((Op != 4'd1) || (Addr[1:0] != 2'b00) || off_hit[3]))
      exc = 5'd4;
    else if (sel && is_store &&
             ((Op != 4'd6) || (Addr[1:0] != 2'b00) || off_hit[3] || off_hit[2]))
      exc = 5'd5;
  end

  assign ExcCodeOut = exc;

  always_comb begin
    ReadData = 32'h0;
    if (sel && (Op == 4'd1) && (exc == 5'd0)) begin
      case (Addr[3:2])
        2'd0:    ReadData = {28'b0, ctrl_reg};
        2'd1:    ReadData = preset_reg;
        2'd2:    ReadData = count_reg;
        default: ReadData = 32'h0;
      endcase
    end
  end

  assign we        = sel && (Op == 4'd6) && (exc == 5'd0) && !Req;
  assign we_ctrl   = we && off_hit[0];
  assign we_preset = we && off_hit[1];

  // PRESET writes are independent of the FSM; a CTRL write preempts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      ctrl_reg     <= 4'd0;
      preset_reg   <= 32'd0;
      count_reg    <= 32'd0;
      irq_flag_reg <= 1'b0;
    end else begin
      if (we_preset)
        preset_reg <= WriteData;
      if (we_ctrl) begin
        ctrl_reg     <= WriteData[3:0];
        state_reg    <= ST_IDLE;
        irq_flag_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (ctrl_reg[0])
              state_reg <= ST_LOAD;
          end
          ST_LOAD: begin
            count_reg <= preset_reg;
            state_reg <= ST_CNT;
          end
          ST_CNT: begin
            if (!ctrl_reg[0]) begin
              state_reg <= ST_IDLE;
            end else if (count_reg > 32'd1) begin
              count_reg <= count_reg - 32'd1;
            end else begin
              count_reg    <= 32'd0;
              irq_flag_reg <= 1'b1;
              state_reg    <= ST_INT;
            end
          end
          ST_INT: begin
            // MODE 1x behaves as one-shot.
            if (ctrl_reg[2:1] == 2'b01) begin
              irq_flag_reg <= 1'b0;
              state_reg    <= ST_LOAD;
            end else begin
              ctrl_reg[0] <= 1'b0;
              state_reg   <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign IRQ = irq_flag_reg & ctrl_reg[3];

endmodule

// File: tb/tb_bridge_timer.sv
// Directed bench for bridge_timer: register access, timer modes, exceptions,
// write suppression, mid-count abort and reset.
module tb_bridge_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'd0;
  localparam logic [31:0] A_PRESET = BASE + 32'd4;
  localparam logic [31:0] A_COUNT  = BASE + 32'd8;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [3:0]  Op;
  logic [4:0]  ExcCodeIn;
  logic        Req;
  logic [31:0] ReadData;
  logic [4:0]  ExcCodeOut;
  logic        IRQ;

  int total;
  int bad;

  bridge_timer #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData), .Op(Op),
    .ExcCodeIn(ExcCodeIn), .Req(Req), .ReadData(ReadData),
    .ExcCodeOut(ExcCodeOut), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Store occupying exactly one rising edge.
  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; Op = 4'd6;
    step();
    Op = 4'd0;
  endtask

  // Combinational load check between edges.
  task automatic lw_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Addr = a; Op = 4'd1;
    #1;
    check(tag, ReadData, exp);
    Op = 4'd0;
  endtask

  task automatic exc_check(input string tag, input logic [31:0] a, input logic [3:0] op,
                           input logic [4:0] ein, input logic [4:0] exp);
    Addr = a; Op = op; ExcCodeIn = ein;
    #1;
    check(tag, {27'b0, ExcCodeOut}, {27'b0, exp});
  endtask

  int cnt_pat [8] = '{0, 2, 1, 0, 0, 2, 1, 0};
  logic [7:0] irq_pat = 8'b1000_1000;

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; Addr = 32'h0; WriteData = 32'h0; Op = 4'd0; ExcCodeIn = 5'd0; Req = 1'b0;

    #2;
    check("rst_irq", {31'b0, IRQ}, 32'd0);
    lw_check("rst_ctrl", A_CTRL, 32'h0);
    lw_check("rst_count", A_COUNT, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // One-shot, PRESET=3
    sw(A_PRESET, 32'd3);
    lw_check("preset_rd", A_PRESET, 32'd3);
    sw(A_CTRL, 32'h9);
    step();
    lw_check("os_e1_count", A_COUNT, 32'd0);
    step(); lw_check("os_count3", A_COUNT, 32'd3);
    step(); lw_check("os_count2", A_COUNT, 32'd2);
    step(); lw_check("os_count1", A_COUNT, 32'd1);
    check("os_irq_pre", {31'b0, IRQ}, 32'd0);
    step(); lw_check("os_count0", A_COUNT, 32'd0);
    check("os_irq_set", {31'b0, IRQ}, 32'd1);
    lw_check("os_ctrl_int", A_CTRL, 32'h9);
    step(); lw_check("os_en_clr", A_CTRL, 32'h8);
    check("os_irq_hold1", {31'b0, IRQ}, 32'd1);
    step(); step();
    check("os_irq_hold2", {31'b0, IRQ}, 32'd1);
    sw(A_CTRL, 32'h0);
    check("os_irq_clr", {31'b0, IRQ}, 32'd0);

    // Auto-reload, PRESET=2, IM=1
    sw(A_PRESET, 32'd2);
    sw(A_CTRL, 32'hB);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("ar_irq_e%0d", i + 1), {31'b0, IRQ}, {31'b0, irq_pat[i]});
      lw_check($sformatf("ar_cnt_e%0d", i + 1), A_COUNT, 32'(cnt_pat[i]));
    end
    // Auto-reload with IM=0
    sw(A_CTRL, 32'h3);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("arm_irq_e%0d", i + 1), {31'b0, IRQ}, 32'd0);
      lw_check($sformatf("arm_cnt_e%0d", i + 1), A_COUNT, 32'(cnt_pat[i]));
    end
    sw(A_CTRL, 32'h0);

    // Address exceptions
    exc_check("exc_lh_ctrl", A_CTRL, 4'd2, 5'd0, 5'd4);
    check("exc_lh_rd", ReadData, 32'h0);
    exc_check("exc_sw_count", A_COUNT, 4'd6, 5'd0, 5'd5);
    WriteData = 32'h123; step(); Op = 4'd0;
    lw_check("exc_count_kept", A_COUNT, 32'd0);
    exc_check("exc_sw_mis", BASE + 32'd2, 4'd6, 5'd0, 5'd5);
    WriteData = 32'hF; step(); Op = 4'd0;
    lw_check("exc_ctrl_kept", A_CTRL, 32'h0);
    exc_check("exc_lw_12", BASE + 32'd12, 4'd1, 5'd0, 5'd4);
    check("exc_lw12_rd", ReadData, 32'h0);
    exc_check("exc_sb_preset", A_PRESET, 4'd8, 5'd0, 5'd5);
    WriteData = 32'h77; step(); Op = 4'd0;
    lw_check("exc_preset_kept", A_PRESET, 32'd2);
    exc_check("exc_in6", A_CTRL, 4'd1, 5'd6, 5'd6);
    check("exc_in6_rd", ReadData, 32'h0);
    exc_check("exc_unsel", 32'h0000_1000, 4'd1, 5'd0, 5'd0);
    check("unsel_rd", ReadData, 32'h0);
    Op = 4'd0; ExcCodeIn = 5'd0;

    // Write suppression by Req
    Req = 1'b1;
    sw(A_PRESET, 32'h55);
    lw_check("req_rd_valid", A_PRESET, 32'd2);
    Req = 1'b0;
    sw(A_PRESET, 32'h55);
    lw_check("req_off_wr", A_PRESET, 32'h55);

    // CTRL=0 mid-count holds COUNT
    sw(A_PRESET, 32'd8);
    sw(A_CTRL, 32'h1);
    step(); step(); step(); step(); step();
    lw_check("mid_count5", A_COUNT, 32'd5);
    sw(A_CTRL, 32'h0);
    lw_check("mid_hold_a", A_COUNT, 32'd5);
    step(); step();
    lw_check("mid_hold_b", A_COUNT, 32'd5);
    lw_check("mid_ctrl0", A_CTRL, 32'h0);

    // Asynchronous reset mid-count
    sw(A_PRESET, 32'd9);
    sw(A_CTRL, 32'h9);
    step(); step(); step(); step();
    lw_check("ar_count7", A_COUNT, 32'd7);
    reset = 1'b0;
    #1;
    lw_check("arst_count", A_COUNT, 32'h0);
    lw_check("arst_preset", A_PRESET, 32'h0);
    lw_check("arst_ctrl", A_CTRL, 32'h0);
    check("arst_irq", {31'b0, IRQ}, 32'd0);
    step();
    reset = 1'b1;
    step(); step(); step(); step();
    lw_check("arst_no_resume", A_COUNT, 32'h0);
    check("arst_irq_after", {31'b0, IRQ}, 32'd0);

    // PRESET=0 one-shot boundary
    sw(A_PRESET, 32'd0);
    sw(A_CTRL, 32'h9);
    step();
    check("p0_irq_e1", {31'b0, IRQ}, 32'd0);
    lw_check("p0_cnt_e1", A_COUNT, 32'd0);
    step();
    check("p0_irq_e2", {31'b0, IRQ}, 32'd0);
    lw_check("p0_cnt_e2", A_COUNT, 32'd0);
    step();
    check("p0_irq_e3", {31'b0, IRQ}, 32'd1);
    lw_check("p0_cnt_e3", A_COUNT, 32'd0);
    step();
    lw_check("p0_en_clr", A_CTRL, 32'h8);
    lw_check("p0_cnt_e4", A_COUNT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
